// File: rtl/controller_eval_sequencer.sv
// Purpose : sequences the infix reduce loop (stack pops, ALU starts, final push or result).
// Latency : accept->done 3 cycles without reduction; each reduction adds 3 + ALU latency.
// Backpr. : req_ready high only in IDLE; req_valid elsewhere is dropped, not queued.
//
// Ports:
//   Clock, Reset                      clock, synchronous active-low reset
//   req_valid/ready/final/op/num      evaluation request (operator key or '=')
//   dt_*                              data stack top/status and pop/push strobes
//   op_*                              operator stack top/status and pop/push strobes
//   pr_top/pr_new/pr_res              precedence ROM query and answer
//   al_*                              ALU start/operands and done/result/error
//   done/result/err                   completion pulse, result, sticky error
module controller_eval_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_final,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_num,
    input  logic [DATA_W-1:0] dt_data,
    input  logic              dt_empty,
    input  logic              dt_full,
    output logic              dt_pop,
    output logic              dt_push,
    output logic [DATA_W-1:0] dt_wdata,
    input  logic [OP_W-1:0]   op_data,
    input  logic              op_empty,
    input  logic              op_full,
    output logic              op_pop,
    output logic              op_push,
    output logic [OP_W-1:0]   op_wdata,
    output logic [OP_W-1:0]   pr_top,
    output logic [OP_W-1:0]   pr_new,
    input  logic              pr_res,
    output logic              al_start,
    output logic [DATA_W-1:0] al_A,
    output logic [DATA_W-1:0] al_B,
    output logic [OP_W-1:0]   al_op,
    input  logic              al_done,
    input  logic [DATA_W-1:0] al_C,
    input  logic              al_err,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_POP, S_CALC, S_WAIT, S_PUSH, S_DONE, S_ERROR
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_lhs;
    logic [DATA_W-1:0] r_result;
    logic [OP_W-1:0]   r_opr;
    logic [OP_W-1:0]   r_aop;
    logic              r_fin;
    logic              r_err;
    logic              r_req_ready;
    logic              r_dt_pop;
    logic              r_op_pop;
    logic              r_dt_push;
    logic              r_op_push;
    logic              r_al_start;
    logic              r_done;

    // Only this block moves the stacks, so their full flags seen in CHECK
    // are still valid in PUSH; the push strobe can thus be registered on
    // entry to PUSH and the PUSH-state decision stays consistent with it.
    logic w_push_ok;
    assign w_push_ok = !r_fin && !dt_full && !op_full;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_lhs       <= '0;
            r_result    <= '0;
            r_opr       <= '0;
            r_aop       <= '0;
            r_fin       <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_dt_pop    <= 1'b0;
            r_op_pop    <= 1'b0;
            r_dt_push   <= 1'b0;
            r_op_push   <= 1'b0;
            r_al_start  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // all strobes are single-cycle unless re-asserted below
            r_dt_pop   <= 1'b0;
            r_op_pop   <= 1'b0;
            r_dt_push  <= 1'b0;
            r_op_push  <= 1'b0;
            r_al_start <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_acc       <= req_num;
                        r_opr       <= req_op;
                        r_fin       <= req_final;
                        r_req_ready <= 1'b0;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (op_empty) begin
                        r_dt_push <= w_push_ok;
                        r_op_push <= w_push_ok;
                        r_state   <= S_PUSH;
                    end else if (dt_empty) begin
                        // an operator with no left operand: stack underflow
                        r_err   <= 1'b1;
                        r_state <= S_ERROR;
                    end else if (r_fin || pr_res) begin
                        // '=' drains everything; otherwise equal precedence
                        // also reduces, giving left associativity
                        r_dt_pop <= 1'b1;
                        r_op_pop <= 1'b1;
                        r_state  <= S_POP;
                    end else begin
                        r_dt_push <= w_push_ok;
                        r_op_push <= w_push_ok;
                        r_state   <= S_PUSH;
                    end
                end
                S_POP: begin
                    r_lhs      <= dt_data;
                    r_aop      <= op_data;
                    r_al_start <= 1'b1;
                    r_state    <= S_CALC;
                end
                S_CALC: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (al_done) begin
                        if (al_err) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERROR;
                        end else begin
                            r_acc   <= al_C;
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_PUSH: begin
                    if (!r_fin && (dt_full || op_full)) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERROR;
                    end else begin
                        // result is loaded with the done pulse so it is valid
                        // from the pulse onward
                        r_done   <= 1'b1;
                        r_result <= r_acc;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ERROR: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_err   <= 1'b1;
                    r_state <= S_ERROR;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign dt_pop    = r_dt_pop;
    assign op_pop    = r_op_pop;
    assign dt_push   = r_dt_push;
    assign op_push   = r_op_push;
    assign dt_wdata  = r_acc;
    assign op_wdata  = r_opr;
    assign pr_top    = op_data;
    assign pr_new    = r_opr;
    assign al_start  = r_al_start;
    assign al_A      = r_lhs;
    assign al_B      = r_acc;
    assign al_op     = r_aop;
    assign done      = r_done;
    assign result    = r_result;
    assign err       = r_err;

endmodule
